// File: rtl/game_input_pkg.sv
`default_nettype none
// ==================================================================
// game_input_pkg : HID keycodes, held-vector layout, direction enum
// Rev 1.0
// ==================================================================
package game_input_pkg;

  localparam logic [7:0] KC_A        = 8'h04;
  localparam logic [7:0] KC_D        = 8'h07;
  localparam logic [7:0] KC_W        = 8'h1A;
  localparam logic [7:0] KC_LEFT     = 8'h50;
  localparam logic [7:0] KC_RIGHT    = 8'h4F;
  localparam logic [7:0] KC_UP       = 8'h52;
  localparam logic [7:0] KC_P        = 8'h13;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;

  localparam int CD_W = 6;

  // Bit positions in the held/edge vectors; P2 bits exist only in two-player builds
  localparam int H_L1 = 0;
  localparam int H_R1 = 1;
  localparam int H_F1 = 2;
  localparam int H_P  = 3;
  localparam int H_L2 = 4;
  localparam int H_R2 = 5;
  localparam int H_F2 = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  function automatic logic slot_hit(input logic [3:0][7:0] slots, input logic [7:0] kc);
    slot_hit = (slots[0] == kc) || (slots[1] == kc) || (slots[2] == kc) || (slots[3] == kc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// ==================================================================
// player_ctrl : direction FSM and cooldown-gated fire for one player
// Rev 1.0
// ==================================================================
module player_ctrl
  import game_input_pkg::*;
#(
  parameter int unsigned FIRE_COOLDOWN_FRAMES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic held_l_i,
  input  logic held_r_i,
  input  logic held_f_i,
  input  logic edge_l_i,
  input  logic edge_r_i,
  input  logic edge_f_i,
  input  logic frame_tick_i,
  input  logic paused_i,
  output logic left_o,
  output logic right_o,
  output logic fire_o
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN_FRAMES);

  dir_t            state_q, state_d;
  logic [CD_W-1:0] cnt_q, cnt_d;
  logic            fire_q, fire_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    // paused_i is the upcoming pause state, so outputs clear in the toggle cycle
    if (paused_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (held_l_i && !held_r_i)      state_d = LEFT;
          else if (held_r_i && !held_l_i) state_d = RIGHT;
        end
        LEFT: begin
          if (edge_r_i || (!held_l_i && held_r_i)) state_d = RIGHT;
          else if (!held_l_i && !held_r_i)         state_d = IDLE;
        end
        RIGHT: begin
          if (edge_l_i || (!held_r_i && held_l_i)) state_d = LEFT;
          else if (!held_l_i && !held_r_i)         state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (edge_f_i && (cnt_q == '0)) begin
        fire_d = 1'b1;
        cnt_d  = CD_LOAD;
      end else if (frame_tick_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign left_o  = (state_q == LEFT);
  assign right_o = (state_q == RIGHT);
  assign fire_o  = fire_q;

endmodule
`default_nettype wire

// File: rtl/keycode_decoder.sv
`default_nettype none
// ==================================================================
// keycode_decoder : HID slots -> per-player controls and pause toggle
// Optional feature macro: TWO_PLAYER_EN (undefined: arrows alias P1)
// Rev 1.0
// ==================================================================
module keycode_decoder
  import game_input_pkg::*;
#(
  parameter int unsigned FIRE_COOLDOWN_FRAMES = 20
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode_export,
  input  logic [7:0] keycode2_export,
  input  logic [7:0] keycode3_export,
  input  logic [7:0] keycode4_export,
  input  logic       frame_tick,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p1_fire,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p2_fire,
  output logic       paused
);

`ifdef TWO_PLAYER_EN
  localparam int HW = 7;
`else
  localparam int HW = 4;
`endif

  logic [3:0][7:0] slot_q;
  logic [HW-1:0]   held_q, held_d, prev_q, edge_w;
  logic            paused_q, paused_d;

  always_comb begin
    held_d = held_q;
    // ErrorRollOver in every slot means the report is unreliable; keep last state
    if (slot_q != {4{KC_ROLLOVER}}) begin
      held_d[H_P] = slot_hit(slot_q, KC_P);
`ifdef TWO_PLAYER_EN
      held_d[H_L1] = slot_hit(slot_q, KC_A);
      held_d[H_R1] = slot_hit(slot_q, KC_D);
      held_d[H_F1] = slot_hit(slot_q, KC_W);
      held_d[H_L2] = slot_hit(slot_q, KC_LEFT);
      held_d[H_R2] = slot_hit(slot_q, KC_RIGHT);
      held_d[H_F2] = slot_hit(slot_q, KC_UP);
`else
      held_d[H_L1] = slot_hit(slot_q, KC_A) || slot_hit(slot_q, KC_LEFT);
      held_d[H_R1] = slot_hit(slot_q, KC_D) || slot_hit(slot_q, KC_RIGHT);
      held_d[H_F1] = slot_hit(slot_q, KC_W) || slot_hit(slot_q, KC_UP);
`endif
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      slot_q   <= '0;
      held_q   <= '0;
      prev_q   <= '0;
      paused_q <= 1'b0;
    end else begin
      slot_q   <= {keycode4_export, keycode3_export, keycode2_export, keycode_export};
      held_q   <= held_d;
      prev_q   <= held_q;
      paused_q <= paused_d;
    end
  end

  assign edge_w   = held_q & ~prev_q;
  assign paused_d = paused_q ^ edge_w[H_P];
  assign paused   = paused_q;

  player_ctrl #(
    .FIRE_COOLDOWN_FRAMES(FIRE_COOLDOWN_FRAMES)
  ) u_p1 (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .held_l_i    (held_q[H_L1]),
    .held_r_i    (held_q[H_R1]),
    .held_f_i    (held_q[H_F1]),
    .edge_l_i    (edge_w[H_L1]),
    .edge_r_i    (edge_w[H_R1]),
    .edge_f_i    (edge_w[H_F1]),
    .frame_tick_i(frame_tick),
    .paused_i    (paused_d),
    .left_o      (p1_left),
    .right_o     (p1_right),
    .fire_o      (p1_fire)
  );

`ifdef TWO_PLAYER_EN
  player_ctrl #(
    .FIRE_COOLDOWN_FRAMES(FIRE_COOLDOWN_FRAMES)
  ) u_p2 (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .held_l_i    (held_q[H_L2]),
    .held_r_i    (held_q[H_R2]),
    .held_f_i    (held_q[H_F2]),
    .edge_l_i    (edge_w[H_L2]),
    .edge_r_i    (edge_w[H_R2]),
    .edge_f_i    (edge_w[H_F2]),
    .frame_tick_i(frame_tick),
    .paused_i    (paused_d),
    .left_o      (p2_left),
    .right_o     (p2_right),
    .fire_o      (p2_fire)
  );
`else
  assign p2_left  = 1'b0;
  assign p2_right = 1'b0;
  assign p2_fire  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keycode_decoder.sv
`default_nettype none
// ==================================================================
// tb_keycode_decoder : directed self-checking bench for keycode_decoder
// Rev 1.0
// ==================================================================
module tb_keycode_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] kc1 = 8'h00, kc2 = 8'h00, kc3 = 8'h00, kc4 = 8'h00;
  logic       tick = 1'b0;
  logic       p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire, paused;
  logic       a_left, a_fire;

  int checks = 0;
  int errors = 0;
  int pulses;
  int lost;

  keycode_decoder #(.FIRE_COOLDOWN_FRAMES(20)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .keycode_export (kc1),
    .keycode2_export(kc2),
    .keycode3_export(kc3),
    .keycode4_export(kc4),
    .frame_tick     (tick),
    .p1_left        (p1_left),
    .p1_right       (p1_right),
    .p1_fire        (p1_fire),
    .p2_left        (p2_left),
    .p2_right       (p2_right),
    .p2_fire        (p2_fire),
    .paused         (paused)
  );

  always #5 clk = ~clk;

  // Arrow keys drive P2 in two-player builds and alias P1 otherwise
`ifdef TWO_PLAYER_EN
  assign a_left = p2_left;
  assign a_fire = p2_fire;
`else
  assign a_left = p1_left;
  assign a_fire = p1_fire;
`endif

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset();
    kc1 = 8'h00; kc2 = 8'h00; kc3 = 8'h00; kc4 = 8'h00; tick = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    kc1 = 8'h04;
    rst_n = 1'b0;
    step(4);
    checks++;
    if ({p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire, paused} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire, paused});
    end
    do_reset();
  endtask

  task automatic test_move();
    kc1 = 8'h04;
    step(2);
    checks++;
    if (p1_left !== 1'b0) begin errors++; $display("FAIL left_early: got %b want 0", p1_left); end
    step(1);
    checks++;
    if ({p1_left, p1_right} !== 2'b10) begin errors++; $display("FAIL left_press: got %b want 10", {p1_left, p1_right}); end
    kc1 = 8'h00;
    step(2);
    checks++;
    if (p1_left !== 1'b1) begin errors++; $display("FAIL left_release_early: got %b want 1", p1_left); end
    step(1);
    checks++;
    if (p1_left !== 1'b0) begin errors++; $display("FAIL left_release: got %b want 0", p1_left); end
  endtask

  task automatic test_conflict();
    kc1 = 8'h04;
    step(3);
    kc2 = 8'h07;
    step(3);
    checks++;
    if ({p1_left, p1_right} !== 2'b01) begin errors++; $display("FAIL conflict_r_edge: got %b want 01", {p1_left, p1_right}); end
    kc2 = 8'h00;
    step(3);
    checks++;
    if ({p1_left, p1_right} !== 2'b10) begin errors++; $display("FAIL conflict_back_left: got %b want 10", {p1_left, p1_right}); end
    kc1 = 8'h00;
    step(3);
    kc1 = 8'h04; kc2 = 8'h07;
    step(4);
    checks++;
    if ({p1_left, p1_right} !== 2'b00) begin errors++; $display("FAIL idle_both_held: got %b want 00", {p1_left, p1_right}); end
    kc1 = 8'h00; kc2 = 8'h00;
    step(3);
  endtask

  task automatic test_fire();
    kc1 = 8'h1A;
    pulses = 0;
    repeat (100) begin step(1); if (p1_fire) pulses++; end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL fire_hold: got %0d pulses want 1", pulses); end
    kc1 = 8'h00; step(4);
    ticks(5);
    kc1 = 8'h1A;
    pulses = 0;
    repeat (10) begin step(1); if (p1_fire) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL fire_cooldown_5: got %0d pulses want 0", pulses); end
    kc1 = 8'h00; step(4);
    ticks(15);
    kc1 = 8'h1A;
    pulses = 0;
    repeat (10) begin step(1); if (p1_fire) pulses++; end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL fire_cooldown_20: got %0d pulses want 1", pulses); end
    kc1 = 8'h00; step(4);
  endtask

  task automatic test_fire_tick_collision();
    ticks(20);
    kc1 = 8'h1A;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    checks++;
    if (p1_fire !== 1'b1) begin errors++; $display("FAIL fire_with_tick: got %b want 1", p1_fire); end
    kc1 = 8'h00; step(4);
    ticks(19);
    kc1 = 8'h1A;
    pulses = 0;
    repeat (10) begin step(1); if (p1_fire) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL load_wins_19: got %0d pulses want 0", pulses); end
    kc1 = 8'h00; step(4);
    ticks(1);
    kc1 = 8'h1A;
    pulses = 0;
    repeat (10) begin step(1); if (p1_fire) pulses++; end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL load_wins_20: got %0d pulses want 1", pulses); end
    kc1 = 8'h00; step(4);
  endtask

  task automatic test_rollover();
    do_reset();
    kc1 = 8'h07;
    step(3);
    checks++;
    if (p1_right !== 1'b1) begin errors++; $display("FAIL roll_pre: got %b want 1", p1_right); end
    kc1 = 8'h01; kc2 = 8'h01; kc3 = 8'h01; kc4 = 8'h01;
    pulses = 0; lost = 0;
    repeat (10) begin
      step(1);
      if (p1_fire) pulses++;
      if (p1_right !== 1'b1) lost++;
    end
    checks++;
    if (lost !== 0) begin errors++; $display("FAIL roll_hold: got %0d cycles with right low want 0", lost); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL roll_fire: got %0d pulses want 0", pulses); end
    kc1 = 8'h07; kc2 = 8'h00; kc3 = 8'h00; kc4 = 8'h00;
    step(4);
    checks++;
    if ({p1_left, p1_right} !== 2'b01) begin errors++; $display("FAIL roll_post: got %b want 01", {p1_left, p1_right}); end
    kc1 = 8'h00; step(3);
  endtask

  task automatic test_pause();
    do_reset();
    kc1 = 8'h50;
    step(3);
    checks++;
    if (a_left !== 1'b1) begin errors++; $display("FAIL pause_pre_left: got %b want 1", a_left); end
`ifndef TWO_PLAYER_EN
    checks++;
    if ({p2_left, p2_right, p2_fire} !== 3'b000) begin errors++; $display("FAIL p2_tied: got %b want 000", {p2_left, p2_right, p2_fire}); end
`endif
    kc3 = 8'h52;
    step(3);
    checks++;
    if (a_fire !== 1'b1) begin errors++; $display("FAIL pause_pre_fire: got %b want 1", a_fire); end
    kc3 = 8'h00; step(3);
    kc2 = 8'h13;
    step(2);
    checks++;
    if (paused !== 1'b0) begin errors++; $display("FAIL pause_early: got %b want 0", paused); end
    step(1);
    checks++;
    if ({paused, a_left} !== 2'b10) begin errors++; $display("FAIL pause_on: got %b want 10", {paused, a_left}); end
    kc2 = 8'h00; step(3);
    ticks(25);
    kc3 = 8'h52;
    pulses = 0;
    repeat (6) begin step(1); if (a_fire) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL pause_fire_suppressed: got %0d pulses want 0", pulses); end
    kc3 = 8'h00; step(3);
    kc2 = 8'h13;
    step(3);
    checks++;
    if ({paused, a_left} !== 2'b01) begin errors++; $display("FAIL pause_off: got %b want 01", {paused, a_left}); end
    kc2 = 8'h00; step(3);
    kc3 = 8'h52;
    pulses = 0;
    repeat (6) begin step(1); if (a_fire) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL cooldown_frozen: got %0d pulses want 0", pulses); end
    kc3 = 8'h00; step(3);
    ticks(20);
    kc3 = 8'h52;
    pulses = 0;
    repeat (6) begin step(1); if (a_fire) pulses++; end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL cooldown_resume: got %0d pulses want 1", pulses); end
    kc1 = 8'h00; kc3 = 8'h00; step(3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    kc1 = 8'h04; kc2 = 8'h1A;
    step(2);
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({p1_left, p1_right, p1_fire, paused} !== 4'b0000) begin
      errors++; $display("FAIL reset_drops_pending: got %b want 0000", {p1_left, p1_right, p1_fire, paused});
    end
    step(1);
    rst_n = 1'b1;
    kc1 = 8'h00; kc2 = 8'h00;
    step(3);
    kc1 = 8'h1A;
    step(3);
    checks++;
    if (p1_fire !== 1'b1) begin errors++; $display("FAIL pre_mid_pulse: got %b want 1", p1_fire); end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire, paused} !== 7'b0) begin
      errors++; $display("FAIL reset_mid_pulse: got %b want 0000000",
                         {p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire, paused});
    end
    rst_n = 1'b1;
    kc1 = 8'h00;
    step(2);
  endtask

  initial begin
    test_reset();
    test_move();
    test_conflict();
    test_fire();
    test_fire_tick_collision();
    test_rollover();
    test_pause();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keycode_decoder.md
# keycode_decoder

Converts the four USB HID keycode slots exported by the Nios II SoC (keycode, keycode2..4) into per-player game controls for Bubble Trouble. It sits directly downstream of the SoC's keycode PIO exports and upstream of the player/harpoon logic. It resolves left/right conflicts, turns fire keys into cooldown-gated single pulses, and owns the global pause toggle.

## Interface
- FIRE_COOLDOWN_FRAMES, 20: frames after an accepted fire during which further fire presses are dropped (1..63).
- clk_clk  input  1  system clock (50 MHz), all logic on rising edge
- reset_reset_n  input  1  synchronous, active-low reset
- keycode_export, keycode2_export, keycode3_export, keycode4_export  input  8 each  HID keycode slots; 0x00 = empty
- frame_tick  input  1  one-cycle pulse per VGA frame (vsync)
- p1_left, p1_right  output  1 each  player 1 movement level; never both 1
- p1_fire  output  1  player 1 one-cycle fire pulse
- p2_left, p2_right, p2_fire  output  1 each  same for player 2
- paused  output  1  pause state level

## Operation
- Key map: P1 A=0x04 left, D=0x07 right, W=0x1A fire. P2 Left=0x50, Right=0x4F, Up=0x52 fire. Pause P=0x13. A key is held if any of the 4 slots equals its code.
- Stage 1 registers the 4 slots. Stage 2 computes held vector and previous held vector (rising-edge detect).
- Rollover: if all 4 slots equal 0x01 (ErrorRollOver), held vector keeps its previous value. No edges are generated.
- Direction FSM per player, states IDLE/LEFT/RIGHT, evaluated each cycle:
  - IDLE: only L held -> LEFT; only R held -> RIGHT; both held -> IDLE.
  - LEFT: R rising edge -> RIGHT; L released and R held -> RIGHT; neither held -> IDLE; else stay. RIGHT is symmetric.
  - Outputs: left = (state==LEFT), right = (state==RIGHT).
- Fire per player: 6-bit cooldown counter.
  - On a fire-key rising edge with counter==0: fire pulses for 1 cycle and the counter loads FIRE_COOLDOWN_FRAMES.
  - Counter decrements on frame_tick while nonzero.
  - An edge with counter!=0 is dropped, not queued. A held key never refires.
- Pause: a rising edge of P toggles paused.
  - While paused, movement outputs are forced 0, FSMs are held in IDLE, fire is suppressed, and cooldown counters are frozen.
  - Edges seen while paused are consumed.
- Simultaneous frame_tick and accepted fire: the load wins. The counter holds FIRE_COOLDOWN_FRAMES.

## Timing
- Reset (reset_reset_n=0 at clock edge): all outputs 0, FSMs IDLE, counters 0, sampled slots and held vectors 0. Takes effect on the first edge. Mid-operation reset drops any pending pulse that cycle.
- Latency: a slot change at edge n is visible on outputs after edge n+2 (2-cycle pipeline, registered outputs).
- Fire pulse width is exactly 1 cycle.
- Pause toggles 2 cycles after the P slot change. Movement outputs go to 0 in that same cycle.
- Cooldown: after a fire at cycle c, the next fire is accepted only after FIRE_COOLDOWN_FRAMES frame_tick pulses following c.

## Configuration
- TWO_PLAYER_EN defined: behaviour exactly as above.
- TWO_PLAYER_EN undefined:
  - p2_* outputs are tied to 0 and P2 logic is not instantiated.
  - Arrow keys alias P1: 0x50 ORs into P1 left, 0x4F into P1 right, 0x52 into P1 fire.

## Structure
- Package game_input_pkg holds:
  - keycode constants (KC_A, KC_D, KC_W, KC_LEFT, KC_RIGHT, KC_UP, KC_P, KC_ROLLOVER)
  - dir_t enum {IDLE, LEFT, RIGHT}
  - cooldown width constant (6)
- Sub-module player_ctrl contains the direction FSM plus fire/cooldown logic. Inputs: held L/R/F, edge L/R/F, frame_tick, paused. It is instantiated once per player.
- keycode_decoder contains slot sampling, the match/edge logic and pause.

## Test plan
- Reset then keycode=0x04 -> p1_left=1 two cycles later, p1_right=0. Release to 0x00 -> p1_left=0 two cycles later.
- Hold 0x04, then set keycode2=0x07 -> p1_right=1, p1_left=0. Clear keycode2 -> returns to p1_left=1.
- keycode=0x1A held 100 cycles -> exactly one p1_fire pulse. Re-press after 5 frame_ticks -> no pulse (FIRE_COOLDOWN_FRAMES=20). Re-press after 20 ticks -> pulse.
- Hold 0x50, then press 0x13 -> paused=1 and p2_left=0. Press 0x13 again -> paused=0 and p2_left=1. Verify cooldown frozen across pause.
- Hold 0x07, then all slots=0x01 for 10 cycles -> p1_right stays 1 and no fire pulses.
- Fire accepted in the same cycle as frame_tick -> counter reads 20. Assert reset mid-pulse -> all outputs 0 next cycle.
